btb_update_queue: RTL and testbench

BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

---
 rtl/btb_update_queue.sv | 132 +++++++++++++
 tb/tb_btb_update_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_queue.sv
`timescale 1ns/1ps
// Purpose: queues resolved-branch records from execute and drains them into the BTB/predictor write port.
// Latency: a record enqueued into an empty queue is presented on btb_w_en in the cycle after its accept edge.
// Backpressure: upd_ready drops while all DEPTH entries are occupied; a head entry is held until btb_w_ack.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   upd_valid/upd_ready             record handshake from execute (upd_pc, upd_target, upd_taken, upd_mispred)
//   btb_w_en/btb_w_ack              write request to the BTB, popped on en && ack
//   btb_w_addr/btb_tag/btb_target/btb_taken   head record fields (index pc[11:2], tag pc[31:12])
//   q_count                         current occupancy
//   stat_branches/stat_mispred      event counters, present only when BP_STATS_EN is defined (else tied to 0)
module btb_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [31:0]              upd_pc,
  input  logic [31:0]              upd_target,
  input  logic                     upd_taken,
  input  logic                     upd_mispred,
  output logic                     btb_w_en,
  input  logic                     btb_w_ack,
  output logic [9:0]               btb_w_addr,
  output logic [19:0]              btb_tag,
  output logic [31:0]              btb_target,
  output logic                     btb_taken,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispred
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [9:0]  addr;
    logic [19:0] tag;
    logic [31:0] target;
    logic        taken;
  } ent_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q, state_d;
  ent_t            mem [DEPTH];
  ent_t            in_ent;
  ent_t            head_q;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic            accept, enq, pop;

  // Word-offset bits of the PC never reach the BTB.
  logic            unused_pc_lsb;
  assign unused_pc_lsb = ^upd_pc[1:0];

  assign in_ent  = '{addr: upd_pc[11:2], tag: upd_pc[31:12], target: upd_target, taken: upd_taken};
  assign rd_next = rd_ptr + AW'(1);

  assign upd_ready = (q_count != CW'(DEPTH));
  assign accept    = upd_valid && upd_ready;
  // Not-taken, correctly predicted branches need no BTB change.
  assign enq       = accept && (upd_taken || upd_mispred);
  assign pop       = btb_w_en && btb_w_ack;

  assign btb_w_en   = (state_q == ISSUE);
  assign btb_w_addr = head_q.addr;
  assign btb_tag    = head_q.tag;
  assign btb_target = head_q.target;
  assign btb_taken  = head_q.taken;

  // Storage is not reset; only entries behind wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_ent;
  end

  // The head is kept in its own register so the outputs are zero out of reset
  // and keep their last value once the queue empties. Its next value is either
  // the incoming record (queue empty or about to empty) or the entry behind the
  // one being popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      head_q  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_next;
      case ({enq, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
      if (enq && (q_count == '0 || (pop && q_count == CW'(1))))
        head_q <= in_ent;
      else if (pop && q_count > CW'(1))
        head_q <= mem[rd_next];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enq) state_d = ISSUE;
      ISSUE: if (pop && q_count == CW'(1) && !enq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (accept) begin
      stat_branches <= stat_branches + 32'd1;
      if (upd_mispred) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_btb_update_queue.sv
`timescale 1ns/1ps
// Bench for btb_update_queue: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_btb_update_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_mispred = 1'b0, btb_w_ack = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic        upd_ready, btb_w_en, btb_taken;
  logic [9:0]  btb_w_addr;
  logic [19:0] btb_tag;
  logic [31:0] btb_target, stat_branches, stat_mispred;
  logic [2:0]  q_count;

  always #5 clk = ~clk;

  btb_update_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .btb_w_en(btb_w_en), .btb_w_ack(btb_w_ack), .btb_w_addr(btb_w_addr), .btb_tag(btb_tag),
    .btb_target(btb_target), .btb_taken(btb_taken), .q_count(q_count),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
  } rec_t;

  rec_t        mq[$];
  rec_t        wlog[$];
  int unsigned m_br = 0, m_mp = 0;
  int          n_checks = 0, n_err = 0;
  bit          chk_on = 1'b0;
  int          base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of records, written from the handshake rules alone.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_br = 0;
      m_mp = 0;
    end else begin
      bit   acc, pp;
      rec_t r;
      acc = upd_valid && (mq.size() != DEPTH);
      pp  = (mq.size() != 0) && btb_w_ack;
      if (pp) wlog.push_back(mq.pop_front());
      if (acc) begin
        m_br++;
        if (upd_mispred) m_mp++;
        if (upd_taken || upd_mispred) begin
          r.pc = upd_pc; r.tgt = upd_target; r.tk = upd_taken;
          mq.push_back(r);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("upd_ready", upd_ready, mq.size() != DEPTH);
      check("q_count", q_count, mq.size());
      check("btb_w_en", btb_w_en, mq.size() != 0);
      if (mq.size() != 0) begin
        check("btb_w_addr", btb_w_addr, mq[0].pc[11:2]);
        check("btb_tag", btb_tag, mq[0].pc[31:12]);
        check("btb_target", btb_target, mq[0].tgt);
        check("btb_taken", btb_taken, mq[0].tk);
      end
`ifdef BP_STATS_EN
      check("stat_branches", stat_branches, m_br);
      check("stat_mispred", stat_mispred, m_mp);
`else
      check("stat_branches", stat_branches, 0);
      check("stat_mispred", stat_mispred, 0);
`endif
    end
  end

  task automatic push_start(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic mp);
    @(negedge clk);
    upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_mispred = mp; upd_valid = 1'b1;
  endtask

  // Hold the record until an edge with upd_ready high takes it; bounded.
  task automatic push_wait();
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      bit r;
      r = upd_ready;
      @(posedge clk);
      #1;
      done = r;
    end
    upd_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL push_timeout: record 0x%0h not accepted within 20 cycles", upd_pc);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic mp);
    push_start(pc, tgt, tk, mp);
    push_wait();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_upd_ready", upd_ready, 1);
    check("rst_q_count", q_count, 0);
    check("rst_btb_w_en", btb_w_en, 0);
    check("rst_btb_w_addr", btb_w_addr, 0);
    check("rst_btb_tag", btb_tag, 0);
    check("rst_btb_target", btb_target, 0);
    check("rst_btb_taken", btb_taken, 0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Single push, ack held high: one write cycle then idle
    btb_w_ack = 1'b1;
    push(32'h0000_1A04, 32'h0000_2000, 1'b1, 1'b0);
    check("single_w_en", btb_w_en, 1);
    check("single_addr", btb_w_addr, 10'h281);
    check("single_tag", btb_tag, 20'h00001);
    check("single_target", btb_target, 32'h2000);
    @(posedge clk); #1;
    check("single_idle_w_en", btb_w_en, 0);
    check("single_idle_count", q_count, 0);

    // Filtered record: not-taken and correctly predicted
    push(32'h0000_3000, 32'h0000_4000, 1'b0, 1'b0);
    check("filter_w_en", btb_w_en, 0);
    check("filter_count", q_count, 0);

    // Backpressure: fill with ack low, fifth record waits
    @(negedge clk); btb_w_ack = 1'b0;
    base = wlog.size();
    for (int k = 0; k < 4; k++) push(32'h100 + 4 * k, 32'h500 + 4 * k, 1'b1, 1'b0);
    check("full_ready", upd_ready, 0);
    check("full_count", q_count, 4);
    push_start(32'h110, 32'h510, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check("held_ready", upd_ready, 0);
      check("held_count", q_count, 4);
    end
    @(negedge clk); btb_w_ack = 1'b1;
    push_wait();
    repeat (6) @(posedge clk);
    #1;
    check("bp_drained_w_en", btb_w_en, 0);
    check("bp_write_count", wlog.size() - base, 5);
    for (int k = 0; k < 5; k++) check("bp_order", wlog[base + k].pc, 32'h100 + 4 * k);

    // Simultaneous push/pop at occupancy 2, wrapping the pointers
    @(negedge clk); btb_w_ack = 1'b0;
    base = wlog.size();
    push(32'h200, 32'h1200, 1'b1, 1'b0);
    push(32'h204, 32'h1204, 1'b0, 1'b1);
    btb_w_ack = 1'b1;
    for (int k = 2; k < 8; k++) begin
      push(32'h200 + 4 * k, 32'h1200 + 4 * k, 1'b1, 1'b0);
      check("pp_count", q_count, 2);
    end
    repeat (4) @(posedge clk);
    #1;
    check("pp_write_count", wlog.size() - base, 8);
    for (int k = 0; k < 8; k++) check("pp_order", wlog[base + k].pc, 32'h200 + 4 * k);

    // Reset while issuing with three queued records
    @(negedge clk); btb_w_ack = 1'b0;
    for (int k = 0; k < 3; k++) push(32'h300 + 4 * k, 32'h700, 1'b1, 1'b0);
    check("pre_rst_count", q_count, 3);
    check("pre_rst_w_en", btb_w_en, 1);
    @(negedge clk); btb_w_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_w_en", btb_w_en, 0);
    check("rst_mid_count", q_count, 0);
    check("rst_mid_ready", upd_ready, 1);
    check("rst_mid_addr", btb_w_addr, 0);
    check("rst_mid_target", btb_target, 0);
    @(negedge clk);
    rst = 1'b0;
    // First edge after deassertion must accept
    upd_pc = 32'h0000_5404; upd_target = 32'h0000_6000; upd_taken = 1'b1; upd_mispred = 1'b0;
    upd_valid = 1'b1;
    push_wait();
    check("post_rst_w_en", btb_w_en, 1);
    check("post_rst_addr", btb_w_addr, 10'h101);
    check("post_rst_tag", btb_tag, 20'h00005);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", btb_w_en, 0);

    // Statistics: 10 accepted records, 3 mispredicted
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 10; k++)
      push(32'h800 + 4 * k, 32'h900, (k % 3) == 0, (k == 1 || k == 4 || k == 7));
    repeat (3) @(posedge clk);
    #1;
`ifdef BP_STATS_EN
    check("stats_branches", stat_branches, 10);
    check("stats_mispred", stat_mispred, 3);
`else
    check("stats_branches", stat_branches, 0);
    check("stats_mispred", stat_mispred, 0);
`endif
    check("stats_idle", btb_w_en, 0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
